ctrl_pipe_carrier: RTL
======================

Name: ctrl_pipe_carrier

Overview:
- Receiving end of the ID-stage control decoder. Latches the decoded control bundle and register fields, then carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers of the SAD datapath.
- Detects load-use and RAW hazards, inserts bubbles, and honours branch flushes.
- Optionally generates forwarding selects.
- Counts retired (valid) instructions.

Parameters:
- ALUOP_W, 4, width of the ALUOp field
- REG_W, 5, register-specifier width
- CNT_W, 16, retired-instruction counter width

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Rst  input  1  synchronous, active-high reset
- ID_Valid  input  1  ID stage holds a real instruction
- ID_RegWrite, ID_RegDst, ID_ALUSrc, ID_Branch, ID_MemWrite, ID_MemRead, ID_MemToReg, ID_zeroExt  input  1 each  decoded control from the ID decoder
- ID_ALUOp  input  ALUOP_W  decoded ALU operation
- ID_Rs, ID_Rt, ID_Rd  input  REG_W each  instruction register fields
- Flush  input  1  branch taken; discard younger instructions
- Stall  output  1  hold PC and IF/ID (PCWrite = IFIDWrite = ~Stall)
- EX_ALUSrc, EX_zeroExt  output  1 each  EX-stage control
- EX_ALUOp  output  ALUOP_W  EX-stage ALU operation
- EX_Rs, EX_Rt, EX_Dst  output  REG_W each  EX-stage register fields
- MEM_Branch, MEM_MemWrite, MEM_MemRead  output  1 each  MEM-stage control
- MEM_Dst  output  REG_W  MEM-stage destination
- WB_RegWrite, WB_MemToReg  output  1 each  WB-stage control
- WB_Dst  output  REG_W  WB-stage destination
- ForwardA, ForwardB  output  2 each  ALU operand source selects
- InstrCount  output  CNT_W  retired-instruction counter

Behaviour:
- Clock and reset: one clock (Clk); reset (Rst) is synchronous and active-high.
- Reset: Rst has priority over all other inputs. On reset, every stage register, its valid bit and InstrCount clear to 0. Every registered output reads 0. Stall, ForwardA and ForwardB are combinational and evaluate to 0 once the registers are cleared.
- Stage registers: ID/EX, EX/MEM and MEM/WB each hold a valid bit, their control subset and Dst. ID/EX also holds Rs and Rt.
- Dst at capture: Dst = ID_RegDst ? ID_Rd : ID_Rt.
- Bubble: valid = 0 and all control fields 0. A bubble never writes a register, never writes memory and is never counted.
- Latency: an instruction in ID at cycle n appears on EX_* at n+1, MEM_* at n+2 and WB_* at n+3.
- Rt-source rule: ID reads Rt iff ID_RegDst = 1 (R-type) or ID_MemWrite = 1 (store).
- Load-use hazard: IDEX.valid & IDEX.MemRead & IDEX.Dst != 0 & ID_Valid, and IDEX.Dst matches ID_Rs, or matches ID_Rt under the Rt-source rule.
- Stall = hazard & ~Flush.
- On Stall: ID/EX loads a bubble and EX/MEM and MEM/WB advance normally. The stall lasts exactly one cycle, because the load leaves EX.
- On Flush: ID/EX and EX/MEM load bubbles and MEM/WB advances normally. Flush overrides Stall.
- Register file writes in the first half-cycle and reads in the second, so WB-stage matches never stall.
- InstrCount increments when MEM/WB.valid = 1 at the clock edge. It wraps modulo 2^CNT_W.
- Register $0: destination 0 never causes a hazard, stall or forward.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- Defined, forwarding selects:
  - ForwardA = 2'b10 if EXMEM.valid & EXMEM.RegWrite & EXMEM.Dst != 0 & EXMEM.Dst == IDEX.Rs.
  - Otherwise 2'b01 if the same condition holds on MEM/WB.
  - Otherwise 2'b00.
  - ForwardB is identical using IDEX.Rt.
  - EX/MEM has priority over MEM/WB.
  - Only the load-use hazard stalls.
- Undefined:
  - ForwardA and ForwardB are tied to 2'b00.
  - The hazard condition is additionally raised when ID/EX or EX/MEM is valid with RegWrite = 1 and a nonzero Dst matching an ID source (same Rt-source rule).
  - Stalls repeat until the producer reaches WB.

Decomposition:
- Package ctrl_pipe_pkg:
  - Packed typedefs ex_ctrl_t, mem_ctrl_t and wb_ctrl_t.
  - Localparams FWD_NONE = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10.
  - Bubble constants for each stage type.
- Sub-module hazard_fwd_unit: purely combinational; computes Stall and the forward selects from the stage registers and the ID fields.
- The top level holds the three stage registers and the counter.

Test Plan:
- Straight flow: ID_Valid = 1, addi with Rt = 5, RegDst = 0, ALUOp = 4'b0001 at cycle 0.
  - EX_ALUOp = 4'b0001 at cycle 1, MEM_Dst = 5 at cycle 2, WB_RegWrite = 1 and WB_Dst = 5 at cycle 3.
  - InstrCount = 1 after cycle 4.
- Load-use: load with Rt = 8 in EX and MemRead = 1; ID holds an R-type with Rs = 8.
  - Stall = 1 for exactly one cycle, EX_* is all zeros the next cycle, and the R-type reaches EX one cycle later.
- Forward priority (CTRL_PIPE_FWD_EN): EX/MEM and MEM/WB both write $9 and IDEX.Rs = 9.
  - ForwardA = 2'b10.
  - With only MEM/WB writing $9: ForwardA = 2'b01.
  - With destination $0: ForwardA = 2'b00 and Stall = 0.
- Flush with hazard: load-use condition true and Flush = 1 in the same cycle.
  - Stall = 0; EX_* and MEM_* are zeros next cycle.
  - InstrCount does not count the flushed instructions.
- Reset mid-run: three valid instructions in flight, then Rst = 1 for one cycle.
  - Next cycle every output is 0, including InstrCount and Stall.
- Wrap: preload by running 2^CNT_W - 1 retirements, then retire one more.
  - InstrCount = 0.

Source files
------------

// File: rtl/ctrl_pipe_carrier_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : ctrl_pipe_pkg                                                 |
// | Description : Shared types for the ID/EX, EX/MEM and MEM/WB control          |
// |               carrier: per-stage control bundles, their bubble values and   |
// |               the forwarding-select encodings.                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package ctrl_pipe_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_NONE  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEMWB = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // operand from EX/MEM result

  // Control consumed in EX (ALUOp is carried separately so its width
  // can follow the top-level parameter).
  typedef struct packed {
    logic alu_src;
    logic zero_ext;
  } ex_ctrl_t;

  // Control consumed in MEM
  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
  } mem_ctrl_t;

  // Control consumed in WB
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_carrier_if.sv
// +----------------------------------------------------------------------------+
// | Interface   : ctrl_pipe_carrier_if                                          |
// | Description : Bundle between the ID-stage decoder/fetch side (master) and   |
// |               the pipeline control carrier (slave).                         |
// |               master -> slave : ID_* decoded control and register fields,   |
// |                                 Flush                                       |
// |               slave -> master : Stall, EX_*, MEM_*, WB_* stage control,     |
// |                                 ForwardA/ForwardB, InstrCount               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ctrl_pipe_carrier_if #(
  parameter int ALUOP_W = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
);

  // ID-stage inputs
  logic               ID_Valid;
  logic               ID_RegWrite;
  logic               ID_RegDst;
  logic               ID_ALUSrc;
  logic               ID_Branch;
  logic               ID_MemWrite;
  logic               ID_MemRead;
  logic               ID_MemToReg;
  logic               ID_zeroExt;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic [REG_W-1:0]   ID_Rs;
  logic [REG_W-1:0]   ID_Rt;
  logic [REG_W-1:0]   ID_Rd;
  logic               Flush;

  // Carrier outputs
  logic               Stall;
  logic               EX_ALUSrc;
  logic               EX_zeroExt;
  logic [ALUOP_W-1:0] EX_ALUOp;
  logic [REG_W-1:0]   EX_Rs;
  logic [REG_W-1:0]   EX_Rt;
  logic [REG_W-1:0]   EX_Dst;
  logic               MEM_Branch;
  logic               MEM_MemWrite;
  logic               MEM_MemRead;
  logic [REG_W-1:0]   MEM_Dst;
  logic               WB_RegWrite;
  logic               WB_MemToReg;
  logic [REG_W-1:0]   WB_Dst;
  logic [1:0]         ForwardA;
  logic [1:0]         ForwardB;
  logic [CNT_W-1:0]   InstrCount;

  modport master (
    output ID_Valid, ID_RegWrite, ID_RegDst, ID_ALUSrc, ID_Branch,
           ID_MemWrite, ID_MemRead, ID_MemToReg, ID_zeroExt, ID_ALUOp,
           ID_Rs, ID_Rt, ID_Rd, Flush,
    input  Stall, EX_ALUSrc, EX_zeroExt, EX_ALUOp, EX_Rs, EX_Rt, EX_Dst,
           MEM_Branch, MEM_MemWrite, MEM_MemRead, MEM_Dst,
           WB_RegWrite, WB_MemToReg, WB_Dst, ForwardA, ForwardB, InstrCount
  );

  modport slave (
    input  ID_Valid, ID_RegWrite, ID_RegDst, ID_ALUSrc, ID_Branch,
           ID_MemWrite, ID_MemRead, ID_MemToReg, ID_zeroExt, ID_ALUOp,
           ID_Rs, ID_Rt, ID_Rd, Flush,
    output Stall, EX_ALUSrc, EX_zeroExt, EX_ALUOp, EX_Rs, EX_Rt, EX_Dst,
           MEM_Branch, MEM_MemWrite, MEM_MemRead, MEM_Dst,
           WB_RegWrite, WB_MemToReg, WB_Dst, ForwardA, ForwardB, InstrCount
  );

endinterface

`default_nettype wire

// File: rtl/ctrl_pipe_carrier_hazard_fwd_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : hazard_fwd_unit                                               |
// | Description : Combinational hazard detection and forwarding-select logic.   |
// |               Optional feature macro: CTRL_PIPE_FWD_EN                      |
// |                 defined   - EX/MEM and MEM/WB forwarding selects, only      |
// |                             load-use stalls                                 |
// |                 undefined - selects tied to FWD_NONE, any RAW on an ID/EX   |
// |                             or EX/MEM producer also stalls                  |
// | Ports       : id_*        ID-stage validity, sources and Rt-use qualifiers  |
// |               flush       branch taken (suppresses stall)                   |
// |               idex_*, exmem_*, memwb_*  stage register contents            |
// |               stall       hold PC and IF/ID, bubble into ID/EX              |
// |               forward_a/b ALU operand source selects                        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reg_dst,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [REG_W-1:0] idex_dst,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_valid,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] exmem_dst,
  input  logic             memwb_valid,
  input  logic             memwb_reg_write,
  input  logic [REG_W-1:0] memwb_dst,
  output logic             stall,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b
);

  // Does a producer destination collide with a source the ID instruction
  // actually reads?  Rt is a source only for R-type and stores; $0 never
  // collides because it is hard-wired.
  function automatic logic src_hit(
    input logic [REG_W-1:0] dst,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             rt_used
  );
    return (dst != '0) && ((dst == rs) || (rt_used && (dst == rt)));
  endfunction

  logic rt_used;
  logic load_use;
  logic hazard;

  assign rt_used  = id_reg_dst | id_mem_write;
  assign load_use = id_valid & idex_valid & idex_mem_read &
                    src_hit(idex_dst, id_rs, id_rt, rt_used);

`ifdef CTRL_PIPE_FWD_EN

  logic unused_fwd_en;
  assign unused_fwd_en = idex_reg_write;

  assign hazard = load_use;

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    forward_a = FWD_NONE;
    if (exmem_valid && exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rs))
      forward_a = FWD_EXMEM;
    else if (memwb_valid && memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rs))
      forward_a = FWD_MEMWB;
  end

  always_comb begin
    forward_b = FWD_NONE;
    if (exmem_valid && exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rt))
      forward_b = FWD_EXMEM;
    else if (memwb_valid && memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rt))
      forward_b = FWD_MEMWB;
  end

`else

  logic unused_no_fwd;
  assign unused_no_fwd = ^{idex_rs, idex_rt, memwb_valid, memwb_reg_write, memwb_dst};

  // Without forwarding, the consumer waits until the producer sits in WB,
  // where the split-phase register file delivers the value directly.
  logic raw;
  assign raw = id_valid &
               ((idex_valid  & idex_reg_write  & src_hit(idex_dst,  id_rs, id_rt, rt_used)) |
                (exmem_valid & exmem_reg_write & src_hit(exmem_dst, id_rs, id_rt, rt_used)));

  assign hazard    = load_use | raw;
  assign forward_a = FWD_NONE;
  assign forward_b = FWD_NONE;

`endif

  // A taken branch discards the waiting instruction anyway.
  assign stall = hazard & ~flush;

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe_carrier.sv
// +----------------------------------------------------------------------------+
// | Module      : ctrl_pipe_carrier                                             |
// | Description : Receives the decoded ID-stage control bundle and carries it   |
// |               through the ID/EX, EX/MEM and MEM/WB registers, inserting     |
// |               bubbles for stalls and branch flushes, and counts retired     |
// |               instructions.                                                 |
// |               Optional feature macro: CTRL_PIPE_FWD_EN (forwarding selects) |
// | Ports       : Clk  - clock, rising edge                                     |
// |               Rst  - synchronous active-high reset                          |
// |               bus  - ctrl_pipe_carrier_if.slave: ID_* and Flush in;         |
// |                      Stall, EX_*, MEM_*, WB_*, ForwardA/B, InstrCount out   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module ctrl_pipe_carrier
  import ctrl_pipe_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  ctrl_pipe_carrier_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ID/EX
  logic               idex_valid;
  ex_ctrl_t           idex_ex;
  mem_ctrl_t          idex_mem;
  wb_ctrl_t           idex_wb;
  logic [ALUOP_W-1:0] idex_aluop;
  logic [REG_W-1:0]   idex_rs;
  logic [REG_W-1:0]   idex_rt;
  logic [REG_W-1:0]   idex_dst;

  // EX/MEM
  logic               exmem_valid;
  mem_ctrl_t          exmem_mem;
  wb_ctrl_t           exmem_wb;
  logic [REG_W-1:0]   exmem_dst;

  // MEM/WB
  logic               memwb_valid;
  wb_ctrl_t           memwb_wb;
  logic [REG_W-1:0]   memwb_dst;

  logic [CNT_W-1:0]   instr_count;

  logic               stall;
  logic [1:0]         forward_a;
  logic [1:0]         forward_b;

  hazard_fwd_unit #(
    .REG_W (REG_W)
  ) u_hazard_fwd_unit (
    .id_valid        (bus.ID_Valid),
    .id_rs           (bus.ID_Rs),
    .id_rt           (bus.ID_Rt),
    .id_reg_dst      (bus.ID_RegDst),
    .id_mem_write    (bus.ID_MemWrite),
    .flush           (bus.Flush),
    .idex_valid      (idex_valid),
    .idex_mem_read   (idex_mem.mem_read),
    .idex_reg_write  (idex_wb.reg_write),
    .idex_dst        (idex_dst),
    .idex_rs         (idex_rs),
    .idex_rt         (idex_rt),
    .exmem_valid     (exmem_valid),
    .exmem_reg_write (exmem_wb.reg_write),
    .exmem_dst       (exmem_dst),
    .memwb_valid     (memwb_valid),
    .memwb_reg_write (memwb_wb.reg_write),
    .memwb_dst       (memwb_dst),
    .stall           (stall),
    .forward_a       (forward_a),
    .forward_b       (forward_b)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idex_valid  <= 1'b0;
      idex_ex     <= EX_BUBBLE;
      idex_mem    <= MEM_BUBBLE;
      idex_wb     <= WB_BUBBLE;
      idex_aluop  <= '0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_dst    <= '0;
      exmem_valid <= 1'b0;
      exmem_mem   <= MEM_BUBBLE;
      exmem_wb    <= WB_BUBBLE;
      exmem_dst   <= '0;
      memwb_valid <= 1'b0;
      memwb_wb    <= WB_BUBBLE;
      memwb_dst   <= '0;
      instr_count <= '0;
    end else begin
      // ID/EX: an empty ID slot, a stall and a flush all become a bubble.
      if (bus.Flush || stall || !bus.ID_Valid) begin
        idex_valid <= 1'b0;
        idex_ex    <= EX_BUBBLE;
        idex_mem   <= MEM_BUBBLE;
        idex_wb    <= WB_BUBBLE;
        idex_aluop <= '0;
        idex_rs    <= '0;
        idex_rt    <= '0;
        idex_dst   <= '0;
      end else begin
        idex_valid <= 1'b1;
        idex_ex    <= '{alu_src: bus.ID_ALUSrc, zero_ext: bus.ID_zeroExt};
        idex_mem   <= '{branch: bus.ID_Branch, mem_write: bus.ID_MemWrite,
                        mem_read: bus.ID_MemRead};
        idex_wb    <= '{reg_write: bus.ID_RegWrite, mem_to_reg: bus.ID_MemToReg};
        idex_aluop <= bus.ID_ALUOp;
        idex_rs    <= bus.ID_Rs;
        idex_rt    <= bus.ID_Rt;
        idex_dst   <= bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
      end

      // EX/MEM: the instruction in EX is younger than the branch in MEM.
      if (bus.Flush) begin
        exmem_valid <= 1'b0;
        exmem_mem   <= MEM_BUBBLE;
        exmem_wb    <= WB_BUBBLE;
        exmem_dst   <= '0;
      end else begin
        exmem_valid <= idex_valid;
        exmem_mem   <= idex_mem;
        exmem_wb    <= idex_wb;
        exmem_dst   <= idex_dst;
      end

      memwb_valid <= exmem_valid;
      memwb_wb    <= exmem_wb;
      memwb_dst   <= exmem_dst;

      if (memwb_valid)
        instr_count <= instr_count + CNT_ONE;
    end
  end

  assign bus.Stall        = stall;
  assign bus.ForwardA     = forward_a;
  assign bus.ForwardB     = forward_b;
  assign bus.EX_ALUSrc    = idex_ex.alu_src;
  assign bus.EX_zeroExt   = idex_ex.zero_ext;
  assign bus.EX_ALUOp     = idex_aluop;
  assign bus.EX_Rs        = idex_rs;
  assign bus.EX_Rt        = idex_rt;
  assign bus.EX_Dst       = idex_dst;
  assign bus.MEM_Branch   = exmem_mem.branch;
  assign bus.MEM_MemWrite = exmem_mem.mem_write;
  assign bus.MEM_MemRead  = exmem_mem.mem_read;
  assign bus.MEM_Dst      = exmem_dst;
  assign bus.WB_RegWrite  = memwb_wb.reg_write;
  assign bus.WB_MemToReg  = memwb_wb.mem_to_reg;
  assign bus.WB_Dst       = memwb_dst;
  assign bus.InstrCount   = instr_count;

endmodule

`default_nettype wire
